// File: rtl/ransac_pkg.sv
// ----------------------------------------------------------------------------
// ransac_pkg
// Shared definitions for the RANSAC sample picker: default widths, slice
// geometry of the random word, index type and FSM state encoding.
// ----------------------------------------------------------------------------
package ransac_pkg;

    localparam int unsigned DEF_SAMPLE_SIZE  = 3;
    localparam int unsigned DEF_INDEX_WIDTH  = 16;
    localparam int unsigned DEF_MAX_ATTEMPTS = 1024;

    // The 64-bit random word is consumed as four 16-bit slices.
    localparam int unsigned WORD_WIDTH      = 64;
    localparam int unsigned SLICE_WIDTH     = 16;
    localparam int unsigned SLICES_PER_WORD = WORD_WIDTH / SLICE_WIDTH;

    typedef logic [DEF_INDEX_WIDTH-1:0] index_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ransac_sample_picker_if.sv
// ----------------------------------------------------------------------------
// ransac_sample_picker_if
// Request/result bus of the sample picker.
//   random_value : 64-bit random word (already in the picker clock domain)
//   start        : request a new sample set
//   point_count  : population size N, sampled with an accepted start
//   busy         : picker is not idle
//   out_valid    : result presented
//   out_ready    : consumer accepts the result
//   out_indices  : packed accepted indices, index k at [k*INDEX_WIDTH +: INDEX_WIDTH]
//   out_error    : result carries no valid set
// master = requester/consumer side, slave = picker side.
// ----------------------------------------------------------------------------
interface ransac_sample_picker_if
    import ransac_pkg::*;
#(
    parameter int unsigned SAMPLE_SIZE = DEF_SAMPLE_SIZE,
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH
);

    logic [WORD_WIDTH-1:0]              random_value;
    logic                               start;
    logic [INDEX_WIDTH-1:0]             point_count;
    logic                               busy;
    logic                               out_valid;
    logic                               out_ready;
    logic [SAMPLE_SIZE*INDEX_WIDTH-1:0] out_indices;
    logic                               out_error;

    modport master (
        output random_value, start, point_count, out_ready,
        input  busy, out_valid, out_indices, out_error
    );

    modport slave (
        input  random_value, start, point_count, out_ready,
        output busy, out_valid, out_indices, out_error
    );

endinterface

// File: rtl/ransac_sample_picker_mask.sv
// ----------------------------------------------------------------------------
// bit_length_mask
// Combinational mask generator: all ones over bit_length(i_value) bits.
//   i_value : N-1 of the population
//   o_mask  : (1 << bit_length(i_value)) - 1  (zero when i_value is zero)
// ----------------------------------------------------------------------------
module bit_length_mask #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_mask
);

    // Smear the most significant set bit down to bit 0.
    always_comb begin
        logic v_seen;
        v_seen = 1'b0;
        o_mask = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            v_seen    = v_seen | i_value[i];
            o_mask[i] = v_seen;
        end
    end

endmodule

// File: rtl/ransac_sample_picker.sv
// ----------------------------------------------------------------------------
// ransac_sample_picker
// Draws SAMPLE_SIZE distinct indices in [0, N) from 16-bit slices of a random
// word using mask-and-reject sampling; gives up after MAX_ATTEMPTS slices.
//   read_clock : sole clock
//   read_reset : asynchronous active-high reset
//   bus        : request/result interface (slave modport)
// ----------------------------------------------------------------------------
module ransac_sample_picker
    import ransac_pkg::*;
#(
    parameter int unsigned SAMPLE_SIZE  = DEF_SAMPLE_SIZE,
    parameter int unsigned INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int unsigned MAX_ATTEMPTS = DEF_MAX_ATTEMPTS
) (
    input  logic                  read_clock,
    input  logic                  read_reset,
    ransac_sample_picker_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_SIZE + 1);
    localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned OUT_W = SAMPLE_SIZE * INDEX_WIDTH;

    state_t                  r_state;
    logic [INDEX_WIDTH-1:0]  r_n;
    logic [WORD_WIDTH-1:0]   r_word;
    logic [1:0]              r_slice;
    logic [CNT_W-1:0]        r_count;
    logic [ATT_W-1:0]        r_attempt;
    logic [OUT_W-1:0]        r_acc;
    logic                    r_busy;
    logic                    r_valid;
    logic                    r_error;
    logic [OUT_W-1:0]        r_indices;

    logic [SLICE_WIDTH-1:0]  w_slice;
    logic [INDEX_WIDTH-1:0]  w_n_m1;
    logic [INDEX_WIDTH-1:0]  w_mask;
    logic [INDEX_WIDTH-1:0]  w_cand;
    logic                    w_dup;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_exhausted;
    logic [ATT_W-1:0]        w_attempt_next;
    logic [OUT_W-1:0]        w_acc_next;

    assign w_n_m1 = r_n - INDEX_WIDTH'(1);

    bit_length_mask #(
        .WIDTH (INDEX_WIDTH)
    ) u_mask (
        .i_value (w_n_m1),
        .o_mask  (w_mask)
    );

    // Candidate evaluation for the current slice.
    always_comb begin
        w_slice = r_word[{r_slice, 4'b0000} +: SLICE_WIDTH];
        w_cand  = INDEX_WIDTH'(w_slice) & w_mask;

        // Only slots already filled in this request take part in the duplicate check.
        w_dup = 1'b0;
        for (int k = 0; k < SAMPLE_SIZE; k++) begin
            if ((CNT_W'(k) < r_count) && (r_acc[k*INDEX_WIDTH +: INDEX_WIDTH] == w_cand)) begin
                w_dup = 1'b1;
            end
        end

        w_accept   = (w_cand < r_n) && !w_dup;
        w_complete = w_accept && (r_count == CNT_W'(SAMPLE_SIZE - 1));

        w_acc_next = r_acc;
        for (int k = 0; k < SAMPLE_SIZE; k++) begin
            if (w_accept && (r_count == CNT_W'(k))) begin
                w_acc_next[k*INDEX_WIDTH +: INDEX_WIDTH] = w_cand;
            end
        end

        w_attempt_next = r_attempt + ATT_W'(1);
        w_exhausted    = (w_attempt_next == ATT_W'(MAX_ATTEMPTS));
    end

    // Control FSM with registered outputs.
    always_ff @(posedge read_clock or posedge read_reset) begin
        if (read_reset) begin
            r_state   <= ST_IDLE;
            r_n       <= '0;
            r_word    <= '0;
            r_slice   <= '0;
            r_count   <= '0;
            r_attempt <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_indices <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_n       <= bus.point_count;
                        r_count   <= '0;
                        r_attempt <= '0;
                        r_acc     <= '0;
                        r_busy    <= 1'b1;
                        // A population smaller than the set size can never succeed.
                        if (bus.point_count < INDEX_WIDTH'(SAMPLE_SIZE)) begin
                            r_state   <= ST_DONE;
                            r_valid   <= 1'b1;
                            r_error   <= 1'b1;
                            r_indices <= '0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    r_word  <= bus.random_value;
                    r_slice <= '0;
                    r_state <= ST_DRAW;
                end

                ST_DRAW: begin
                    r_attempt <= w_attempt_next;
                    r_slice   <= r_slice + 2'd1;
                    r_acc     <= w_acc_next;
                    if (w_accept) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    // Completion takes priority over running out of attempts.
                    if (w_complete) begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_error   <= 1'b0;
                        r_indices <= w_acc_next;
                    end else if (w_exhausted) begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_error   <= 1'b1;
                        r_indices <= '0;
                    end else if (r_slice == 2'd3) begin
                        r_state <= ST_LOAD;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_valid   <= 1'b0;
                        r_error   <= 1'b0;
                        r_indices <= '0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.out_valid   = r_valid;
    assign bus.out_error   = r_error;
    assign bus.out_indices = r_indices;

endmodule
